// File: rtl/mem_pkg.sv
// Shared encodings for the sized data memory: access sizes and controller states.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_RESP} state_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// Little-endian lane steering: byte enables and lane-replicated store data,
// plus lane extraction with sign/zero extension for loads.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata
);

  function automatic logic [31:0] ext_byte(input logic signed [7:0] v, input logic zext);
    logic signed [31:0] s;
    s = v;
    return zext ? {24'h0, v} : s;
  endfunction

  function automatic logic [31:0] ext_half(input logic signed [15:0] v, input logic zext);
    logic signed [31:0] s;
    s = v;
    return zext ? {16'h0, v} : s;
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = raw[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? raw[31:16] : raw[15:0];

  // Data is replicated into every lane so the byte enables alone pick the target.
  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata;
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << lane;
        wdata_lane = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    rdata = raw;
    case (size)
      SZ_BYTE: rdata = ext_byte(byte_sel, uns);
      SZ_HALF: rdata = ext_half(half_sel, uns);
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed MEM-stage data memory with programmable latency, Stall/Ready
// handshake, request rejection, and a word-by-word clear after reset.
module data_mem_sized
  import mem_pkg::*;
#(
  parameter int DEPTH          = 128,
  parameter int LATENCY        = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Stall,
  output logic        Error
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
  localparam state_t      RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t        state, state_nx;
  logic [AW-1:0] clr_idx;
  logic [3:0]    cnt;

  logic [AW+1:0] addr_p1;
  logic [31:0]   wdata_p1;
  logic [1:0]    size_p1;
  logic          uns_p1, wr_p1;

  logic [31:0]   word [0:DEPTH-1];

  logic          req, illegal, accept, reject, commit, in_idle;
  logic [AW+1:0] cur_addr;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata, rdata_fmt, wdata_lane;
  logic [1:0]    cur_size;
  logic          cur_uns, cur_wr;
  logic [3:0]    be;

  assign req     = MemRead | MemWrite;
  assign illegal = (MemRead & MemWrite) | (Size == 2'b11)
                 | ((Size == SZ_HALF) & Address[0])
                 | ((Size == SZ_WORD) & (Address[1:0] != 2'b00))
                 | (Address >= MEM_BYTES);
  assign in_idle = (state == ST_IDLE);
  assign accept  = in_idle & req & ~illegal;
  assign reject  = in_idle & req & illegal;
  assign commit  = (state_nx == ST_RESP);

  // With LATENCY=1 the access commits straight from IDLE, so use the live request.
  assign cur_addr  = in_idle ? Address[AW+1:0] : addr_p1;
  assign cur_wdata = in_idle ? WriteData : wdata_p1;
  assign cur_size  = in_idle ? Size : size_p1;
  assign cur_uns   = in_idle ? Unsigned : uns_p1;
  assign cur_wr    = in_idle ? MemWrite : wr_p1;
  assign cur_idx   = cur_addr[AW+1:2];

  mem_lane_fmt u_fmt (
    .size       (cur_size),
    .uns        (cur_uns),
    .lane       (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .raw        (word[cur_idx]),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata      (rdata_fmt)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= RST_STATE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: if (clr_idx == AW'(DEPTH - 1)) state_nx = ST_IDLE;
      ST_IDLE:  if (accept) state_nx = (CNT_INIT != 4'd0) ? ST_WAIT : ST_RESP;
      ST_WAIT:  if (cnt == 4'd1) state_nx = ST_RESP;
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = RST_STATE;
    endcase
  end

  always_comb begin
    Stall = (state == ST_CLEAR) | (state == ST_WAIT) | accept;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      clr_idx  <= '0;
      cnt      <= '0;
      Ready    <= 1'b0;
      Error    <= 1'b0;
      ReadData <= '0;
    end else begin
      Ready <= commit;
      Error <= reject;
      if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
      if (accept)                 cnt <= CNT_INIT;
      else if (state == ST_WAIT)  cnt <= cnt - 1'b1;
      if (commit && !cur_wr) ReadData <= rdata_fmt;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_p1  <= Address[AW+1:0];
      wdata_p1 <= WriteData;
      size_p1  <= Size;
      uns_p1   <= Unsigned;
      wr_p1    <= MemWrite;
    end
  end

  always_ff @(posedge CLK) begin
    if (state == ST_CLEAR) begin
      word[clr_idx] <= '0;
    end else if (commit && cur_wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) word[cur_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_sized.sv
// Bench for data_mem_sized: two instances (LATENCY=1 and LATENCY=3) driven
// independently and compared against an arithmetic byte-lane memory model.
module tb_data_mem_sized;
  import mem_pkg::*;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0]       rd, wr, uns;
  logic [1:0][1:0]  sz;
  logic [1:0][31:0] addr, wd;

  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, stall0, stall1, err0, err1;

  data_mem_sized #(.DEPTH(128), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut0 (
    .CLK(CLK), .RST_n(RST_n), .MemRead(rd[0]), .MemWrite(wr[0]), .Size(sz[0]),
    .Unsigned(uns[0]), .Address(addr[0]), .WriteData(wd[0]),
    .ReadData(rdata0), .Ready(ready0), .Stall(stall0), .Error(err0)
  );

  data_mem_sized #(.DEPTH(128), .LATENCY(3), .CLEAR_ON_RESET(1'b1)) dut1 (
    .CLK(CLK), .RST_n(RST_n), .MemRead(rd[1]), .MemWrite(wr[1]), .Size(sz[1]),
    .Unsigned(uns[1]), .Address(addr[1]), .WriteData(wd[1]),
    .ReadData(rdata1), .Ready(ready1), .Stall(stall1), .Error(err1)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem_m [2][128];
  logic [31:0] last_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] o_rdata(input int d); return (d != 0) ? rdata1 : rdata0; endfunction
  function automatic logic o_ready(input int d); return (d != 0) ? ready1 : ready0; endfunction
  function automatic logic o_stall(input int d); return (d != 0) ? stall1 : stall0; endfunction
  function automatic logic o_err(input int d);   return (d != 0) ? err1 : err0; endfunction

  function automatic bit model_legal(input logic r, input logic w, input logic [1:0] s,
                                     input logic [31:0] a);
    if (r && w) return 1'b0;
    if (s == 2'b11) return 1'b0;
    if (s == SZ_HALF && (a % 2) != 0) return 1'b0;
    if (s == SZ_WORD && (a % 4) != 0) return 1'b0;
    if (a >= 32'd512) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [1:0] s, input logic u,
                                             input logic [31:0] a);
    logic [31:0] w, v;
    int sh;
    w  = mem_m[d][int'(a >> 2)];
    sh = 8 * int'(a[1:0]);
    case (s)
      SZ_BYTE: begin
        v = (w >> sh) & 32'hFF;
        if (!u && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      SZ_HALF: begin
        v = (w >> sh) & 32'hFFFF;
        if (!u && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic void model_store(input int d, input logic [1:0] s, input logic [31:0] a,
                                      input logic [31:0] wdat);
    logic [31:0] mask;
    int sh, i;
    mask = (s == SZ_BYTE) ? 32'hFF : (s == SZ_HALF) ? 32'hFFFF : 32'hFFFFFFFF;
    sh   = 8 * int'(a[1:0]);
    i    = int'(a >> 2);
    mem_m[d][i] = (mem_m[d][i] & ~(mask << sh)) | ((wdat & mask) << sh);
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 128; i++) mem_m[d][i] = 32'h0;
      last_rd[d] = 32'h0;
    end
  endfunction

  task automatic do_reset();
    int n0, n1, rdy;
    RST_n = 1'b0;
    rd = '0;
    wr = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_ready0", 32'(ready0), 32'h0);
    check("rst_ready1", 32'(ready1), 32'h0);
    check("rst_error0", 32'(err0), 32'h0);
    check("rst_error1", 32'(err1), 32'h0);
    RST_n = 1'b1;
    n0 = 0; n1 = 0; rdy = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (stall0) n0++;
      if (stall1) n1++;
      if (ready0 || ready1) rdy++;
      if (!stall0 && !stall1) break;
    end
    check("clear_len0", n0, 128);
    check("clear_len1", n1, 128);
    check("no_ready_clear", rdy, 0);
    @(posedge CLK);
    #1;
    model_clear();
  endtask

  // Entered and left #1 after a rising edge with the addressed instance in IDLE.
  task automatic access(input int d, input logic r, input logic w, input logic [1:0] s,
                        input logic u, input logic [31:0] a, input logic [31:0] wdat,
                        output logic [31:0] got);
    int n, st, lat;
    logic [31:0] expv;
    lat = (d != 0) ? 3 : 1;
    rd[d] = r; wr[d] = w; sz[d] = s; uns[d] = u; addr[d] = a; wd[d] = wdat;
    if (!model_legal(r, w, s, a)) begin
      @(negedge CLK);
      check("err_nostall", 32'(o_stall(d)), 32'h0);
      @(posedge CLK);
      #1;
      check("err_pulse", 32'(o_err(d)), 32'h1);
      check("err_noready", 32'(o_ready(d)), 32'h0);
      rd[d] = 1'b0; wr[d] = 1'b0;
      @(posedge CLK);
      #1;
      check("err_oneshot", 32'(o_err(d)), 32'h0);
      got = o_rdata(d);
      check("err_rdata_hold", got, last_rd[d]);
      return;
    end
    n = 0; st = 0;
    while (!o_ready(d) && n < 20) begin
      @(negedge CLK);
      if (o_stall(d)) st++;
      @(posedge CLK);
      #1;
      n++;
    end
    check("latency", n, lat);
    check("stall_cycles", st, lat);
    rd[d] = 1'b0; wr[d] = 1'b0;
    if (r) begin
      expv = model_load(d, s, u, a);
      last_rd[d] = expv;
    end else begin
      model_store(d, s, a, wdat);
      expv = last_rd[d];
    end
    got = o_rdata(d);
    check(r ? "load_data" : "store_rdata_hold", got, expv);
    @(negedge CLK);
    check("resp_nostall", 32'(o_stall(d)), 32'h0);
    @(posedge CLK);
    #1;
    check("ready_oneshot", 32'(o_ready(d)), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [31:0] got, a, wdat;
    logic        r, w, u;
    logic [1:0]  s;
    int          d, op;

    rd = '0; wr = '0; sz = '0; uns = '0; addr = '0; wd = '0;
    model_clear();
    do_reset();

    // Freshly cleared memory reads zero everywhere.
    access(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0,   32'h0, got); check("clr_lw_0",   got, 32'h0);
    access(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h1FC, 32'h0, got); check("clr_lw_1fc", got, 32'h0);
    access(1, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h13,  32'h0, got);

    access(1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hA1B2C3D4, got);
    access(1, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, got); check("lb_11",  got, 32'hFFFFFFC3);
    access(1, 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, got); check("lbu_11", got, 32'h000000C3);

    access(1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hA1B2C3D4, got);
    access(1, 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h22, 32'h00008001, got);
    access(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, got); check("sh_merge", got, 32'h8001C3D4);
    access(1, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, got); check("lh_22",    got, 32'hFFFF8001);

    access(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h13,  32'h0,        got);
    access(1, 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h21,  32'h00001234, got);
    access(1, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h20,  32'h55555555, got);
    access(1, 1'b0, 1'b1, 2'b11,   1'b0, 32'h20,  32'h66666666, got);
    access(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0,        got);
    access(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, got); check("illegal_keep_20", got, 32'h8001C3D4);
    access(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, got); check("illegal_keep_10", got, 32'hA1B2C3D4);

    access(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0,        got);
    access(0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h13579BDF, got);
    access(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, got); check("b2b_lw", got, 32'h13579BDF);

    for (int i = 0; i < 160; i++) begin
      d  = i % 2;
      op = int'($urandom_range(0, 9));
      r  = (op < 5) || (op == 9);
      w  = (op >= 5);
      s  = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) a = 32'd508 + 32'($urandom_range(0, 8));
      if ($urandom_range(0, 3) != 0) begin
        if (s == SZ_WORD)      a[1:0] = 2'b00;
        else if (s == SZ_HALF) a[0]   = 1'b0;
      end
      wdat = $urandom;
      access(d, r, w, s, u, a, wdat, got);
    end

    // Abort a store mid-flight with reset; the clear must wipe the old contents.
    access(1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h0BADF00D, got);
    access(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, got); check("pre_abort_30", got, 32'h0BADF00D);
    rd[1] = 1'b0; wr[1] = 1'b1; sz[1] = SZ_WORD; uns[1] = 1'b0;
    addr[1] = 32'h30; wd[1] = 32'hDEADBEEF;
    @(posedge CLK);
    #2;
    check("abort_in_wait_stall", 32'(stall1), 32'h1);
    check("abort_in_wait_ready", 32'(ready1), 32'h0);
    do_reset();
    access(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, got); check("abort_cleared_30", got, 32'h0);
    access(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, got); check("abort_cleared_10", got, 32'h0);

    for (int i = 0; i < 40; i++) begin
      d  = i % 2;
      r  = ($urandom_range(0, 1) == 1);
      w  = !r;
      s  = 2'($urandom_range(0, 2));
      u  = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 31));
      if (s == SZ_WORD)      a[1:0] = 2'b00;
      else if (s == SZ_HALF) a[0]   = 1'b0;
      wdat = $urandom;
      access(d, r, w, s, u, a, wdat, got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
